// File: rtl/matmul_pkg.sv
// Shared constants, FSM state encoding and address helper for the sequential
// matrix multiplier.
package matmul_pkg;

  localparam int DW    = 16;
  localparam int MAXN  = 8;
  localparam int AW    = 6;
  localparam int ACC_W = 32;
  localparam int CW    = $clog2(MAXN);
  localparam int DIM_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

  // Every matrix is stored row-major with a fixed row stride of MAXN.
  function automatic logic [AW-1:0] mat_addr(input logic [CW-1:0] row,
                                             input logic [CW-1:0] col);
    return AW'(row) * AW'(MAXN) + AW'(col);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate: full-width product, sign-extended, wrapping sum.
module matmul_mac
  import matmul_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  input  logic                    load,
  input  logic                    en,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod     = (2*DW)'(a) * (2*DW)'(b);
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= load ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// Sequential C = A x B engine: one MAC, N reads per element, row-major output
// order, with a status word for software / LEDs.
module matmul_seq
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] dim,
  output logic [AW-1:0]    a_addr,
  output logic [AW-1:0]    b_addr,
  output logic             rd_en,
  input  logic [DW-1:0]    a_data,
  input  logic [DW-1:0]    b_data,
  output logic             c_wr_en,
  output logic [AW-1:0]    c_addr,
  output logic [ACC_W-1:0] c_data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      status
);

  state_t                  state, state_nx;
  logic [CW-1:0]           i_q, j_q, k_q, last_q;
  logic                    dim_ok, accept, k_last, elem_last;
  logic                    rd_q, first_q;
  logic                    err_q, done_sticky_q;
  logic [7:0]              wr_count_q;
  logic [15:0]             busy_cycles_q;
  logic signed [ACC_W-1:0] acc;

  assign dim_ok    = (dim != '0) && (dim <= DIM_W'(MAXN));
  assign k_last    = (k_q == last_q);
  assign elem_last = (i_q == last_q) && (j_q == last_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Outputs are decoded from the current state; abort only redirects the
  // next state, so a WRITE in the abort cycle still happens.
  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    c_wr_en  = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start && dim_ok) begin
          accept   = 1'b1;
          state_nx = READ;
        end
      end
      READ: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (abort)       state_nx = IDLE;
        else if (k_last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        state_nx = abort ? IDLE : WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        c_wr_en = 1'b1;
        if (abort)          state_nx = IDLE;
        else if (elem_last) state_nx = FIN;
        else                state_nx = READ;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      last_q <= '0;
    end else if (accept) begin
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      last_q <= CW'(dim - 1'b1);
    end else if (state == READ) begin
      k_q <= k_last ? '0 : k_q + 1'b1;
    end else if (state == WRITE && !elem_last) begin
      if (j_q == last_q) begin
        j_q <= '0;
        i_q <= i_q + 1'b1;
      end else begin
        j_q <= j_q + 1'b1;
      end
    end
  end

  // Read data lags rd_en by one cycle, so the MAC controls are delayed to match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      rd_q    <= rd_en;
      first_q <= rd_en && (k_q == '0);
    end
  end

  matmul_mac u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a_data),
    .b       (b_data),
    .load    (first_q),
    .en      (rd_q),
    .acc     (acc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q         <= 1'b0;
      done_sticky_q <= 1'b0;
      wr_count_q    <= '0;
      busy_cycles_q <= '0;
    end else if (accept) begin
      err_q         <= 1'b0;
      done_sticky_q <= 1'b0;
      wr_count_q    <= '0;
      busy_cycles_q <= '0;
    end else begin
      if (state == IDLE && start && !dim_ok) err_q <= 1'b1;
      if (done)    done_sticky_q <= 1'b1;
      if (c_wr_en) wr_count_q    <= wr_count_q + 8'd1;
      if (busy && busy_cycles_q != 16'hFFFF) busy_cycles_q <= busy_cycles_q + 16'd1;
    end
  end

  assign a_addr = rd_en   ? mat_addr(i_q, k_q) : '0;
  assign b_addr = rd_en   ? mat_addr(k_q, j_q) : '0;
  assign c_addr = c_wr_en ? mat_addr(i_q, j_q) : '0;
  assign c_data = c_wr_en ? acc : '0;
  assign status = {busy, done_sticky_q, err_q, 5'b0, wr_count_q, busy_cycles_q};

endmodule
